// File: rtl/ps2_pkg.sv
// ps2_pkg: state encoding, error-code bit indices and defaults shared by the PS/2 receiver.
package ps2_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;
    localparam int ERR_PARITY = 0;
    localparam int ERR_STOP = 1;
    localparam int DEF_TIMEOUT_CYCLES = 150000;
    localparam int DEF_CNT_W = 18;
    // Odd parity: flag when data plus parity bit hold an even number of ones.
    function automatic logic parity_err(input logic [7:0] data, input logic par);
        return ~^{data, par};
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer for the PS/2 clock/data pair plus clock falling-edge flag.
module ps2_sync_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic i_clk_raw,
    input  logic i_data_raw,
    output logic o_data,
    output logic o_fall
);
    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_clk_raw};
            r_data_sync <= {r_data_sync[0], i_data_raw};
            r_clk_prev  <= r_clk_sync[1];
        end
    end
    assign o_data = r_data_sync[1];
    assign o_fall = r_clk_prev & ~r_clk_sync[1];
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver (start, 8 data LSB first, odd parity, stop).
// Define PS2_RX_TIMEOUT_EN to abandon frames whose clock stalls for TIMEOUT_CYCLES.
module ps2_rx_frame import ps2_pkg::*; #(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic       BYTE_READY,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       TIMEOUT
);
    logic       w_data;
    logic       w_fall;
    ps2_state_t r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_parity;
    logic       r_ready;
    logic [7:0] r_byte;
    logic [1:0] r_err;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2 ** CNT_W) begin : g_bad_cfg
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    ps2_sync_edge u_sync (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_clk_raw  (CLK_MOUSE_IN),
        .i_data_raw (DATA_MOUSE_IN),
        .o_data     (w_data),
        .o_fall     (w_fall)
    );

`ifdef PS2_RX_TIMEOUT_EN
    logic [CNT_W-1:0] r_tcnt;
    logic             r_timeout;
    logic             w_expire;
    assign w_expire = (r_state != ST_IDLE) && (r_tcnt == CNT_W'(TIMEOUT_CYCLES));
    assign TIMEOUT  = r_timeout;
`else
    assign TIMEOUT  = 1'b0;
`endif

    // Expiry outranks a coincident falling edge; READ_ENABLE only gates the start bit.
    always_ff @(posedge CLK) begin
        r_ready <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
        r_timeout <= 1'b0;
        r_tcnt    <= (w_fall || r_state == ST_IDLE) ? '0 : r_tcnt + CNT_W'(1);
`endif
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_byte    <= '0;
            r_err     <= '0;
`ifdef PS2_RX_TIMEOUT_EN
            r_tcnt    <= '0;
`endif
        end
`ifdef PS2_RX_TIMEOUT_EN
        else if (w_expire) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_timeout <= 1'b1;
        end
`endif
        else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    r_state   <= (!w_data && READ_ENABLE) ? ST_DATA : ST_IDLE;
                    r_bit_cnt <= '0;
                end
                ST_DATA: begin
                    r_shift   <= {w_data, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_state   <= (r_bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
                end
                ST_PARITY: begin
                    r_parity <= w_data;
                    r_state  <= ST_STOP;
                end
                ST_STOP: begin
                    r_byte            <= r_shift;
                    r_err[ERR_PARITY] <= parity_err(r_shift, r_parity);
                    r_err[ERR_STOP]   <= ~w_data;
                    r_ready           <= 1'b1;
                    r_state           <= ST_IDLE;
                end
            endcase
        end
    end

    assign BYTE_READY      = r_ready;
    assign BYTE_READ       = r_byte;
    assign BYTE_ERROR_CODE = r_err;
endmodule

// File: doc/ps2_rx_frame.md
PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 150000, sets the CLK cycles allowed between PS/2 clock falling edges inside a frame (1.5 ms at 100 MHz).
REQ-002 Parameter CNT_W, default 18, sets the timeout counter width and SHALL be wide enough to hold TIMEOUT_CYCLES.
REQ-003 CLK  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 CLK_MOUSE_IN  input  1  raw PS/2 clock line, asynchronous to CLK.
REQ-006 DATA_MOUSE_IN  input  1  raw PS/2 data line, asynchronous to CLK.
REQ-007 READ_ENABLE  input  1  receiver enabled by the upstream master state machine; gates frame start only.
REQ-008 BYTE_READY  output  1  one-cycle pulse when a frame completes.
REQ-009 BYTE_READ  output  8  received data byte, held until the next BYTE_READY.
REQ-010 BYTE_ERROR_CODE  output  2  bit0 parity error, bit1 stop-bit error, held with BYTE_READ.
REQ-011 TIMEOUT  output  1  one-cycle pulse when a frame is abandoned.

Function
REQ-012 Both raw lines SHALL pass through a 2-flop synchronizer; a clock falling edge SHALL be flagged when the synchronized clock goes from 1 to 0 between consecutive cycles.
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE -> DATA on a falling edge with data=0 and READ_ENABLE=1; a falling edge with data=1, or with READ_ENABLE=0, SHALL leave the FSM in IDLE.
REQ-015 DATA SHALL sample 8 bits, LSB first, one per falling edge, via a 3-bit counter; the 8th edge SHALL move to PARITY.
REQ-016 PARITY SHALL sample the parity bit on the next falling edge and move to STOP.
REQ-017 STOP SHALL sample the stop bit on the next falling edge and return to IDLE.
REQ-018 On the cycle after the STOP edge is detected, BYTE_READY=1 for exactly 1 cycle, with BYTE_READ and BYTE_ERROR_CODE updated in that same cycle.
REQ-019 Parity is odd: bit0=1 when the 8 data bits plus the parity bit contain an even number of ones.
REQ-020 Stop check: bit1=1 when the sampled stop bit is 0.
REQ-021 A byte with errors SHALL still be reported; interpreting the error code is the consumer's job.
REQ-022 Deasserting READ_ENABLE mid-frame SHALL NOT abort the frame.
REQ-023 A falling edge arriving in the same cycle as a timeout expiry SHALL be ignored and the timeout SHALL take effect.

Reset
REQ-024 While RESET=1, the FSM SHALL go to IDLE, counters and the shift register SHALL clear, and synchronizer flops SHALL be set to 1 (bus idle).
REQ-025 While RESET=1, outputs SHALL be BYTE_READY=0, BYTE_READ=0x00, BYTE_ERROR_CODE=2'b00 and TIMEOUT=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame without a BYTE_READY pulse.

Configuration
REQ-027 With PS2_RX_TIMEOUT_EN defined:
- a counter SHALL clear on every falling edge and whenever the FSM is in IDLE, and increment otherwise;
- when it reaches TIMEOUT_CYCLES outside IDLE, the FSM SHALL return to IDLE, TIMEOUT SHALL pulse for 1 cycle, and BYTE_READY SHALL NOT pulse.
REQ-028 Without PS2_RX_TIMEOUT_EN, no counter SHALL be synthesized, TIMEOUT SHALL be tied to 0, and a stalled frame SHALL wait indefinitely.

Structure
REQ-029 A shared package ps2_pkg SHALL hold the FSM state encoding, the error-code bit indices (ERR_PARITY=0, ERR_STOP=1) and the default TIMEOUT_CYCLES.
REQ-030 A single sub-module, ps2_sync_edge, SHALL implement the 2-flop synchronizer and falling-edge detector, instantiated once per line pair.

Verification
REQ-031 Frame 0xA5 with parity 1 and stop 1, READ_ENABLE=1 -> one BYTE_READY pulse, BYTE_READ=0xA5, BYTE_ERROR_CODE=00.
REQ-032 Frame 0xFA with parity 0 -> BYTE_READ=0xFA, BYTE_ERROR_CODE=01; frame 0x01 with parity 0 and stop 0 -> BYTE_ERROR_CODE=10.
REQ-033 Start bit=1, or READ_ENABLE=0 at start -> no BYTE_READY; a following valid 0x00 frame (parity 1) -> BYTE_READ=0x00.
REQ-034 PS2_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=1000, clock stopped after 4 data bits -> TIMEOUT pulse 1000 cycles after the last edge, FSM in IDLE, then a 0x3C frame is received cleanly.
REQ-035 RESET for 1 cycle after the 5th data bit -> outputs at reset values, no BYTE_READY; the next 0xF4 frame is received with BYTE_ERROR_CODE=00.
REQ-036 READ_ENABLE dropped after the start bit of a 0x55 frame -> frame completes, BYTE_READ=0x55.
